// File: rtl/proporcional_pkg.sv
// Shared definitions for the sequential proportional term (proporcional_seq).
// Holds the controller state encoding and the helpers that derive the
// product and iteration-counter widths from the sample word width.
package proporcional_pkg;

    // Controller states: wait for a sample, multiply, round/range-check, hold result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Full product width of a W x W multiply
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Width of a counter that must hold the value W (one step per multiplier bit)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/proporcional_seq_mult_shift_add.sv
// mult_shift_add: unsigned W x W sequential shift-add multiplier.
// A start pulse (ignored while busy) latches both operands and clears the
// accumulator; one multiplier bit is consumed per cycle for W cycles. done is
// a one-cycle pulse and product is held stable until the next start.
module mult_shift_add
    import proporcional_pkg::*;
#(
    parameter int W = 19
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    output logic                     busy,
    output logic                     done,
    output logic [prod_width(W)-1:0] product
);

    localparam int PW = prod_width(W);
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [PW-1:0] acc_r;
    logic [PW-1:0] mcand_r;
    logic [W-1:0]  mplier_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;

    // Operand load on start, then one shift-add step per cycle until the counter drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !busy_r) begin
                acc_r    <= {PW{1'b0}};
                mcand_r  <= {{W{1'b0}}, a};
                mplier_r <= b;
                cnt_r    <= CNT_LOAD;
                busy_r   <= 1'b1;
            end else if (busy_r) begin
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end else begin
                    acc_r <= acc_r;
                end
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/proporcional_seq.sv
// proporcional_seq: runtime-gain proportional term pk = round(kp*y / 2^FRAC).
// Signed samples are split into sign and magnitude, multiplied by the
// sequential shift-add unit, re-signed, rounded half-up and range-checked.
// Handshake: valid/ready on the sample side and on the result side.
// Optional build macro PROPORCIONAL_SAT_EN: clamp pk on overflow instead of
// wrapping; ovf is reported in both builds.
module proporcional_seq
    import proporcional_pkg::*;
#(
    parameter int W       = 19,
    parameter int FRAC    = 10,
    parameter int KP_INIT = 18
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] y,
    input  logic                kp_load,
    input  logic signed [W-1:0] kp_in,
    output logic signed [W-1:0] kp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] pk,
    output logic                ovf
);

    localparam int PW = prod_width(W);
    localparam int SW = PW + 1;   // signed product needs one extra bit for the sign

    localparam logic signed [W-1:0]  KP_RST = W'(KP_INIT);
    localparam logic [W-1:0]         ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] ZERO_S = {SW{1'b0}};
    localparam logic signed [SW-1:0] HALF_S = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [W-1:0]  PK_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  PK_MIN = {1'b1, {(W-1){1'b0}}};

    state_t                state_r;
    state_t                state_nx_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic signed [W-1:0]   pk_r;
    logic                  ovf_r;
    logic signed [W-1:0]   kp_r;
    logic                  sign_r;

    logic                  accept_s;
    logic [W-1:0]          y_abs_s;
    logic [W-1:0]          kp_abs_s;
    logic                  mul_busy_s;
    logic                  mul_done_s;
    logic [PW-1:0]         prod_s;

    logic signed [SW-1:0]  ext_s;
    logic signed [SW-1:0]  sprod_s;
    logic signed [SW-1:0]  rnd_s;
    logic signed [SW-1:0]  sh_s;
    logic                  fits_s;
    logic signed [W-1:0]   res_pk_s;
    logic                  res_ovf_s;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which fits W unsigned bits
    always_comb begin
        if (y[W-1]) begin
            y_abs_s = ~$unsigned(y) + ONE_W;
        end else begin
            y_abs_s = $unsigned(y);
        end
        if (kp_r[W-1]) begin
            kp_abs_s = ~$unsigned(kp_r) + ONE_W;
        end else begin
            kp_abs_s = $unsigned(kp_r);
        end
    end

    mult_shift_add #(
        .W (W)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s),
        .a       (y_abs_s),
        .b       (kp_abs_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (prod_s)
    );

    // Next-state logic and sample acceptance
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r && !mul_busy_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = MUL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_nx_s = RND;
                end else begin
                    state_nx_s = MUL;
                end
            end
            RND: begin
                state_nx_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Re-sign the magnitude product, round half-up, shift and range-check
    always_comb begin
        ext_s   = {1'b0, prod_s};
        sprod_s = ext_s;
        if (sign_r) begin
            sprod_s = ZERO_S - ext_s;
        end else begin
            sprod_s = ext_s;
        end
        rnd_s  = sprod_s + HALF_S;
        sh_s   = rnd_s >>> FRAC;
        // Fits in W signed bits when everything above the result sign bit is a sign copy
        fits_s = (&sh_s[SW-1:W-1]) || (~|sh_s[SW-1:W-1]);
        if (fits_s) begin
            res_ovf_s = 1'b0;
            res_pk_s  = sh_s[W-1:0];
        end else begin
            res_ovf_s = 1'b1;
`ifdef PROPORCIONAL_SAT_EN
            if (sh_s[SW-1]) begin
                res_pk_s = PK_MIN;
            end else begin
                res_pk_s = PK_MAX;
            end
`else
            res_pk_s = sh_s[W-1:0];
`endif
        end
    end

    // Controller state, registered handshakes and result capture at the rounding step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            pk_r        <= {W{1'b0}};
            ovf_r       <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            if (accept_s) begin
                sign_r <= y[W-1] ^ kp_r[W-1];
            end else begin
                sign_r <= sign_r;
            end
            if (state_r == RND) begin
                pk_r  <= res_pk_s;
                ovf_r <= res_ovf_s;
            end else begin
                pk_r  <= pk_r;
                ovf_r <= ovf_r;
            end
        end
    end

    // Gain register; the multiplier latches its operand at accept, so a load only affects later samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_r <= KP_RST;
        end else if (kp_load) begin
            kp_r <= kp_in;
        end else begin
            kp_r <= kp_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign pk        = pk_r;
    assign ovf       = ovf_r;
    assign kp        = kp_r;

endmodule

// File: tb/tb_proporcional_seq.sv
// Scoreboard bench for proporcional_seq: the driver pushes hand-computed
// expectations at accept time; an independent monitor pops and compares on
// each completed handshake, including accept-to-valid latency.
module tb_proporcional_seq;

    localparam int W       = 19;
    localparam int FRAC    = 10;
    localparam int KP_INIT = 18;

`ifdef PROPORCIONAL_SAT_EN
    localparam logic signed [W-1:0] OV_PK1 = 19'sd262143;
    localparam logic signed [W-1:0] OV_PK2 = 19'sd262143;
`else
    localparam logic signed [W-1:0] OV_PK1 = -19'sd512;
    localparam logic signed [W-1:0] OV_PK2 = 19'sd0;
`endif

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] y         = '0;
    logic                kp_load   = 1'b0;
    logic signed [W-1:0] kp_in     = '0;
    logic signed [W-1:0] kp;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] pk;
    logic                ovf;

    proporcional_seq #(.W(W), .FRAC(FRAC), .KP_INIT(KP_INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .kp_load   (kp_load),
        .kp_in     (kp_in),
        .kp        (kp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pk        (pk),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [W-1:0] pk;
        logic                ovf;
        int                  acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Present one sample; optionally load a new gain on the accepting cycle
    task automatic send(input logic signed [W-1:0] yv, input logic signed [W-1:0] epk,
                        input logic eovf, input bit push, input bit co_load,
                        input logic signed [W-1:0] co_kp);
        int t;
        t = 0;
        @(negedge clk);
        y = yv;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("accept_wait");
        if (co_load) begin
            kp_load = 1'b1;
            kp_in   = co_kp;
        end
        if (push) sb.push_back('{epk, eovf, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        kp_load  = 1'b0;
    endtask

    task automatic load_kp(input logic signed [W-1:0] v);
        @(negedge clk);
        kp_load = 1'b1;
        kp_in   = v;
        @(negedge clk);
        kp_load = 1'b0;
        chk("kp_loaded", kp, v);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(in_ready && sb.size() == 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("idle_wait");
    endtask

    // Monitor: record the first valid cycle, compare on each handshake
    initial begin
        bit   seen;
        int   rise;
        exp_t e;
        seen = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    rise = cyc;
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = sb.pop_front();
                        chk("pk", pk, e.pk);
                        chk("ovf", ovf, e.ovf);
                        chk("latency", rise - e.acc, W + 2);
                    end
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int t;
        // Reset state
        #12;
        chk("rst_kp", kp, 18);
        chk("rst_pk", pk, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_edge", in_ready, 1);

        // Basic products with kp = 18
        send(19'sd1024,  19'sd18,  1'b0, 1'b1, 1'b0, '0);
        send(-19'sd1024, -19'sd18, 1'b0, 1'b1, 1'b0, '0);
        send(19'sd29,    19'sd1,   1'b0, 1'b1, 1'b0, '0);
        send(19'sd28,    19'sd0,   1'b0, 1'b1, 1'b0, '0);
        send(-19'sd262144, -19'sd4608, 1'b0, 1'b1, 1'b0, '0);

        // Gain load during MUL: current result keeps 18, next uses 36
        wait_idle();
        send(19'sd1024, 19'sd18, 1'b0, 1'b1, 1'b0, '0);
        repeat (3) @(negedge clk);
        kp_load = 1'b1;
        kp_in   = 19'sd36;
        @(negedge clk);
        kp_load = 1'b0;
        chk("kp_mid_mul", kp, 36);
        send(19'sd1024, 19'sd36, 1'b0, 1'b1, 1'b0, '0);

        // Gain load coincident with accept: old gain 36 used, then 100
        send(19'sd1024, 19'sd36, 1'b0, 1'b1, 1'b1, 19'sd100);
        chk("kp_coincident", kp, 100);
        send(19'sd1024, 19'sd100, 1'b0, 1'b1, 1'b0, '0);

        // Back-pressure: result held while out_ready is low
        wait_idle();
        out_ready = 1'b0;
        send(-19'sd1024, -19'sd100, 1'b0, 1'b1, 1'b0, '0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("valid_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_pk", pk, -100);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_valid", out_valid, 0);

        // Overflow cases
        wait_idle();
        load_kp(19'sd262143);
        send(19'sd262143, OV_PK1, 1'b1, 1'b1, 1'b0, '0);
        wait_idle();
        load_kp(-19'sd262144);
        send(-19'sd262144, OV_PK2, 1'b1, 1'b1, 1'b0, '0);

        // Reset in the middle of a multiply: aborted, gain restored
        wait_idle();
        send(19'sd1024, 19'sd0, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_pk", pk, 0);
        chk("midrst_kp", kp, 18);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(19'sd29, 19'sd1, 1'b0, 1'b1, 1'b0, '0);
        send(19'sd1024, 19'sd18, 1'b0, 1'b1, 1'b0, '0);

        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
